common_decr5_timer_sched: RTL

- Bank of CH_NUM independent 5-bit countdown timers that share a single instance of the 5-bit unsigned decrement ROM (common_rtlrom_decr5).
- A free-running round-robin service pointer gives one channel per cycle access to the shared decrementer.
- Each channel raises a one-cycle expiry pulse when its count reaches zero.
- Used in the core for retry/backoff and timeout tracking, where count resolution per channel equals CH_NUM cycles.

---
 rtl/common_decr5_timer_sched.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/common_decr5_timer_sched.sv
// Bank of CH_NUM countdown timers sharing one 5-bit decrement ROM through a
// free-running round-robin service pointer; each channel pulses o_expire at zero.

module common_rtlrom_decr5 (
  input  logic [4:0] d,
  output logic [4:0] q,
  output logic       c
);

  // Table lookup of d-1 with borrow; d == 0 wraps to 31 and flags the borrow.
  always_comb begin
    q = 5'd0;
    c = 1'b0;
    case (d)
      5'd0:  begin q = 5'd31; c = 1'b1; end
      5'd1:  q = 5'd0;
      5'd2:  q = 5'd1;
      5'd3:  q = 5'd2;
      5'd4:  q = 5'd3;
      5'd5:  q = 5'd4;
      5'd6:  q = 5'd5;
      5'd7:  q = 5'd6;
      5'd8:  q = 5'd7;
      5'd9:  q = 5'd8;
      5'd10: q = 5'd9;
      5'd11: q = 5'd10;
      5'd12: q = 5'd11;
      5'd13: q = 5'd12;
      5'd14: q = 5'd13;
      5'd15: q = 5'd14;
      5'd16: q = 5'd15;
      5'd17: q = 5'd16;
      5'd18: q = 5'd17;
      5'd19: q = 5'd18;
      5'd20: q = 5'd19;
      5'd21: q = 5'd20;
      5'd22: q = 5'd21;
      5'd23: q = 5'd22;
      5'd24: q = 5'd23;
      5'd25: q = 5'd24;
      5'd26: q = 5'd25;
      5'd27: q = 5'd26;
      5'd28: q = 5'd27;
      5'd29: q = 5'd28;
      5'd30: q = 5'd29;
      5'd31: q = 5'd30;
      default: begin q = 5'd0; c = 1'b0; end
    endcase
  end

endmodule

module common_decr5_timer_sched #(
  parameter  int CH_NUM = 4,
  localparam int CH_W   = $clog2(CH_NUM)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_load_valid,
  input  logic [CH_W-1:0]   i_load_ch,
  input  logic [4:0]        i_load_value,
  output logic              o_load_ready,
  input  logic              i_cancel_valid,
  input  logic [CH_W-1:0]   i_cancel_ch,
  output logic [CH_NUM-1:0] o_busy,
  output logic [CH_NUM-1:0] o_expire,
  output logic              o_err_borrow
);

  logic [CH_W-1:0]   ptr_r;
  logic [4:0]        count_r   [CH_NUM];
  logic [4:0]        count_n_s [CH_NUM];
  logic [CH_NUM-1:0] busy_r;
  logic [CH_NUM-1:0] busy_n_s;
  logic [CH_NUM-1:0] expire_r;
  logic [CH_NUM-1:0] expire_n_s;
  logic              err_r;
  logic              err_n_s;
  logic [4:0]        dec_d_s;
  logic [4:0]        dec_q_s;
  logic              dec_c_s;
  logic              load_acc_s;

  assign dec_d_s      = count_r[ptr_r];
  assign o_load_ready = ~busy_r[i_load_ch];
  assign load_acc_s   = i_load_valid & o_load_ready;

  common_rtlrom_decr5 u_decr (
    .d (dec_d_s),
    .q (dec_q_s),
    .c (dec_c_s)
  );

  // Per-channel next state: accepted load beats cancel, cancel beats service.
  always_comb begin
    busy_n_s   = busy_r;
    expire_n_s = {CH_NUM{1'b0}};
    err_n_s    = err_r;
    for (int i = 0; i < CH_NUM; i++) begin
      count_n_s[i] = count_r[i];
      if (load_acc_s && (i_load_ch == CH_W'(i))) begin
        count_n_s[i] = i_load_value;
        if (i_load_value != 5'd0) begin
          busy_n_s[i] = 1'b1;
        end else begin
          busy_n_s[i]   = 1'b0;
          expire_n_s[i] = 1'b1;
        end
      end else if (i_cancel_valid && (i_cancel_ch == CH_W'(i))) begin
        busy_n_s[i]  = 1'b0;
        count_n_s[i] = 5'd0;
      end else if (busy_r[i] && (ptr_r == CH_W'(i))) begin
        // A busy channel holding zero is corrupt: drop it without expiring.
        if (dec_c_s) begin
          busy_n_s[i] = 1'b0;
          err_n_s     = 1'b1;
        end else begin
          count_n_s[i] = dec_q_s;
          if (dec_d_s == 5'd1) begin
            busy_n_s[i]   = 1'b0;
            expire_n_s[i] = 1'b1;
          end else begin
            busy_n_s[i] = 1'b1;
          end
        end
      end else begin
        count_n_s[i] = count_r[i];
      end
    end
  end

  // State registers; the service pointer never stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_r    <= {CH_W{1'b0}};
      busy_r   <= {CH_NUM{1'b0}};
      expire_r <= {CH_NUM{1'b0}};
      err_r    <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        count_r[i] <= 5'd0;
      end
    end else begin
      ptr_r    <= ptr_r + CH_W'(1);
      busy_r   <= busy_n_s;
      expire_r <= expire_n_s;
      err_r    <= err_n_s;
      for (int i = 0; i < CH_NUM; i++) begin
        count_r[i] <= count_n_s[i];
      end
    end
  end

  assign o_busy       = busy_r;
  assign o_expire     = expire_r;
  assign o_err_borrow = err_r;

endmodule
